// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle MIPS-style controller: state
// encoding, opcode/funct constants, ALU control codes and ALU operation type.
package multicycle_controller_pkg;

   typedef enum logic [3:0] {
      ST_FETCH   = 4'd0,
      ST_DECODE  = 4'd1,
      ST_MEMADR  = 4'd2,
      ST_MEMRD   = 4'd3,
      ST_MEMWB   = 4'd4,
      ST_MEMWR   = 4'd5,
      ST_RTYPEEX = 4'd6,
      ST_ALUWB   = 4'd7,
      ST_BRANCH  = 4'd8,
      ST_IMMEX   = 4'd9,
      ST_IMMWB   = 4'd10,
      ST_JUMP    = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   typedef enum logic [2:0] {
      AOP_ADD   = 3'd0,
      AOP_SUB   = 3'd1,
      AOP_FUNCT = 3'd2,
      AOP_AND   = 3'd3,
      AOP_OR    = 3'd4
   } aluop_t;

   // Where DECODE goes for a given opcode; FETCH means the opcode is illegal.
   function automatic state_t decode_target(input logic [5:0] op, input bit imm_en);
      case (op)
         OP_LW, OP_SW:                decode_target = ST_MEMADR;
         OP_RTYPE:                    decode_target = ST_RTYPEEX;
         OP_BEQ:                      decode_target = ST_BRANCH;
         OP_BNE:                      decode_target = imm_en ? ST_BRANCH : ST_FETCH;
         OP_ADDI, OP_ANDI, OP_ORI:    decode_target = imm_en ? ST_IMMEX : ST_FETCH;
         OP_J:                        decode_target = ST_JUMP;
         default:                     decode_target = ST_FETCH;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_controller_alu_dec.sv
// Combinational ALU decoder: maps the FSM's ALU operation (and funct for
// R-type) to the 3-bit alucontrol code.
module alu_dec
   import multicycle_controller_pkg::*;
(
   input  aluop_t     aluop,
   input  logic [5:0] funct,
   output logic [2:0] alucontrol
);

   // Translate the requested operation into the ALU control code.
   always_comb begin
      alucontrol = ALU_ADD;
      case (aluop)
         AOP_ADD: alucontrol = ALU_ADD;
         AOP_SUB: alucontrol = ALU_SUB;
         AOP_AND: alucontrol = ALU_AND;
         AOP_OR:  alucontrol = ALU_OR;
         AOP_FUNCT: begin
            case (funct)
               FN_ADD:  alucontrol = ALU_ADD;
               FN_SUB:  alucontrol = ALU_SUB;
               FN_AND:  alucontrol = ALU_AND;
               FN_OR:   alucontrol = ALU_OR;
               FN_SLT:  alucontrol = ALU_SLT;
               default: alucontrol = ALU_ADD;
            endcase
         end
         default: alucontrol = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle controller FSM. Outputs are decoded from the registered state
// (plus mem_ready/zero/op where a state needs them); write strobes are
// gated by reset so an aborted instruction cannot write anything.
module multicycle_controller
   import multicycle_controller_pkg::*;
#(
   parameter bit WAIT_EN = 1'b1,
   parameter bit IMM_EN  = 1'b1
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pcen,
   output logic       iord,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       regwrite,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic       ext_zero,
   output logic [1:0] pcsrc,
   output logic [2:0] alucontrol,
   output logic       illegal_op,
   output logic [3:0] state
);

   state_t     state_r;
   state_t     decode_next_s;
   logic       mem_ok_s;
   aluop_t     aluop_s;
   logic       alu_used_s;
   logic [2:0] alu_dec_s;
   logic       pcen_s;
   logic       memwrite_s;
   logic       irwrite_s;
   logic       regwrite_s;
   logic       illegal_s;

   assign decode_next_s = decode_target(op, IMM_EN);
   assign mem_ok_s      = WAIT_EN ? mem_ready : 1'b1;

   alu_dec u_alu_dec (
      .aluop      (aluop_s),
      .funct      (funct),
      .alucontrol (alu_dec_s)
   );

   // State register and next-state sequencing.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_FETCH;
      end else begin
         case (state_r)
            ST_FETCH:   state_r <= mem_ok_s ? ST_DECODE : ST_FETCH;
            ST_DECODE:  state_r <= decode_next_s;
            ST_MEMADR:  state_r <= (op == OP_LW) ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD:   state_r <= mem_ok_s ? ST_MEMWB : ST_MEMRD;
            ST_MEMWB:   state_r <= ST_FETCH;
            ST_MEMWR:   state_r <= mem_ok_s ? ST_FETCH : ST_MEMWR;
            ST_RTYPEEX: state_r <= ST_ALUWB;
            ST_ALUWB:   state_r <= ST_FETCH;
            ST_BRANCH:  state_r <= ST_FETCH;
            ST_IMMEX:   state_r <= ST_IMMWB;
            ST_IMMWB:   state_r <= ST_FETCH;
            ST_JUMP:    state_r <= ST_FETCH;
            default:    state_r <= ST_FETCH;
         endcase
      end
   end

   // Per-state control decode; anything a state does not mention stays 0.
   always_comb begin
      pcen_s     = 1'b0;
      iord       = 1'b0;
      memwrite_s = 1'b0;
      irwrite_s  = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      regwrite_s = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      ext_zero   = 1'b0;
      pcsrc      = 2'b00;
      illegal_s  = 1'b0;
      aluop_s    = AOP_ADD;
      alu_used_s = 1'b0;
      case (state_r)
         ST_FETCH: begin
            alusrcb    = 2'b01;
            alu_used_s = 1'b1;
            irwrite_s  = mem_ok_s;
            pcen_s     = mem_ok_s;
         end
         ST_DECODE: begin
            alusrcb    = 2'b11;
            alu_used_s = 1'b1;
            illegal_s  = (decode_next_s == ST_FETCH);
         end
         ST_MEMADR: begin
            alusrca    = 1'b1;
            alusrcb    = 2'b10;
            alu_used_s = 1'b1;
         end
         ST_MEMRD: begin
            iord = 1'b1;
         end
         ST_MEMWB: begin
            memtoreg   = 1'b1;
            regwrite_s = 1'b1;
         end
         ST_MEMWR: begin
            iord       = 1'b1;
            memwrite_s = 1'b1;
         end
         ST_RTYPEEX: begin
            alusrca    = 1'b1;
            aluop_s    = AOP_FUNCT;
            alu_used_s = 1'b1;
         end
         ST_ALUWB: begin
            regdst     = 1'b1;
            regwrite_s = 1'b1;
         end
         ST_BRANCH: begin
            alusrca    = 1'b1;
            aluop_s    = AOP_SUB;
            alu_used_s = 1'b1;
            pcsrc      = 2'b01;
            pcen_s     = ((op == OP_BEQ) & zero) | ((op == OP_BNE) & ~zero);
         end
         ST_IMMEX: begin
            alusrca    = 1'b1;
            alusrcb    = 2'b10;
            alu_used_s = 1'b1;
            case (op)
               OP_ANDI: begin
                  aluop_s  = AOP_AND;
                  ext_zero = 1'b1;
               end
               OP_ORI: begin
                  aluop_s  = AOP_OR;
                  ext_zero = 1'b1;
               end
               default: aluop_s = AOP_ADD;
            endcase
         end
         ST_IMMWB: begin
            regwrite_s = 1'b1;
         end
         ST_JUMP: begin
            pcsrc  = 2'b10;
            pcen_s = 1'b1;
         end
         default: begin
            alu_used_s = 1'b0;
         end
      endcase
   end

   assign alucontrol = alu_used_s ? alu_dec_s : 3'b000;
   assign pcen       = pcen_s & ~reset;
   assign memwrite   = memwrite_s & ~reset;
   assign irwrite    = irwrite_s & ~reset;
   assign regwrite   = regwrite_s & ~reset;
   assign illegal_op = illegal_s & ~reset;
   assign state      = state_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: instruction-level reference model builds the expected
// per-cycle control vector sequence for each instruction.
module tb_multicycle_controller;
   import multicycle_controller_pkg::*;

   typedef struct packed {
      logic [3:0] st;
      logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
      logic [1:0] alusrcb;
      logic       ext_zero;
      logic [1:0] pcsrc;
      logic [2:0] aluc;
      logic       ill;
   } exp_t;

   logic clk = 1'b0;
   logic reset, zero, mem_ready;
   logic [5:0] op, funct;

   logic pcen1, iord1, memwrite1, irwrite1, regdst1, memtoreg1, regwrite1, alusrca1, ext_zero1, ill1;
   logic [1:0] alusrcb1, pcsrc1;
   logic [2:0] aluc1;
   logic [3:0] state1;
   logic pcen2, iord2, memwrite2, irwrite2, regdst2, memtoreg2, regwrite2, alusrca2, ext_zero2, ill2;
   logic [1:0] alusrcb2, pcsrc2;
   logic [2:0] aluc2;
   logic [3:0] state2;
   exp_t obs1, obs2;

   int checks = 0;
   int errors = 0;
   exp_t eq[$];
   bit   rq[$];

   always #5 clk = ~clk;

   multicycle_controller #(.WAIT_EN(1'b1), .IMM_EN(1'b1)) u_dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
      .pcen(pcen1), .iord(iord1), .memwrite(memwrite1), .irwrite(irwrite1), .regdst(regdst1),
      .memtoreg(memtoreg1), .regwrite(regwrite1), .alusrca(alusrca1), .alusrcb(alusrcb1),
      .ext_zero(ext_zero1), .pcsrc(pcsrc1), .alucontrol(aluc1), .illegal_op(ill1), .state(state1));

   multicycle_controller #(.WAIT_EN(1'b1), .IMM_EN(1'b0)) u_dut_noimm (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
      .pcen(pcen2), .iord(iord2), .memwrite(memwrite2), .irwrite(irwrite2), .regdst(regdst2),
      .memtoreg(memtoreg2), .regwrite(regwrite2), .alusrca(alusrca2), .alusrcb(alusrcb2),
      .ext_zero(ext_zero2), .pcsrc(pcsrc2), .alucontrol(aluc2), .illegal_op(ill2), .state(state2));

   assign obs1 = {state1, pcen1, iord1, memwrite1, irwrite1, regdst1, memtoreg1, regwrite1,
                  alusrca1, alusrcb1, ext_zero1, pcsrc1, aluc1, ill1};
   assign obs2 = {state2, pcen2, iord2, memwrite2, irwrite2, regdst2, memtoreg2, regwrite2,
                  alusrca2, alusrcb2, ext_zero2, pcsrc2, aluc2, ill2};

   function automatic exp_t blank(input logic [3:0] st);
      exp_t e;
      e = '0;
      e.st = st;
      return e;
   endfunction

   function automatic exp_t fetch_e(input logic rdy);
      exp_t e;
      e = blank(4'd0);
      e.alusrcb = 2'b01;
      e.aluc    = 3'b010;
      e.irwrite = rdy;
      e.pcen    = rdy;
      return e;
   endfunction

   function automatic logic [2:0] rtype_alu(input logic [5:0] f);
      case (f)
         6'b100000: return 3'b010;
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   task automatic push(input bit rdy, input exp_t e);
      rq.push_back(rdy);
      eq.push_back(e);
   endtask

   // Expected cycle-by-cycle trace of one instruction starting in FETCH.
   task automatic build(input logic [5:0] o, input logic [5:0] f, input logic z,
                        input int fw, input int mw);
      exp_t e;
      bit legal;
      legal = (o == 6'b100011) || (o == 6'b101011) || (o == 6'b000000) || (o == 6'b000100) ||
              (o == 6'b000101) || (o == 6'b001000) || (o == 6'b001100) || (o == 6'b001101) ||
              (o == 6'b000010);
      for (int i = 0; i < fw; i++) push(1'b0, fetch_e(1'b0));
      push(1'b1, fetch_e(1'b1));
      e = blank(4'd1); e.alusrcb = 2'b11; e.aluc = 3'b010; e.ill = !legal;
      push(1'($urandom_range(0, 1)), e);
      if (!legal) return;
      if (o == 6'b100011 || o == 6'b101011) begin
         e = blank(4'd2); e.alusrca = 1'b1; e.alusrcb = 2'b10; e.aluc = 3'b010;
         push(1'($urandom_range(0, 1)), e);
         if (o == 6'b100011) begin
            e = blank(4'd3); e.iord = 1'b1;
            for (int i = 0; i < mw; i++) push(1'b0, e);
            push(1'b1, e);
            e = blank(4'd4); e.memtoreg = 1'b1; e.regwrite = 1'b1;
            push(1'($urandom_range(0, 1)), e);
         end else begin
            e = blank(4'd5); e.iord = 1'b1; e.memwrite = 1'b1;
            for (int i = 0; i < mw; i++) push(1'b0, e);
            push(1'b1, e);
         end
      end else if (o == 6'b000000) begin
         e = blank(4'd6); e.alusrca = 1'b1; e.aluc = rtype_alu(f);
         push(1'($urandom_range(0, 1)), e);
         e = blank(4'd7); e.regdst = 1'b1; e.regwrite = 1'b1;
         push(1'($urandom_range(0, 1)), e);
      end else if (o == 6'b000100 || o == 6'b000101) begin
         e = blank(4'd8); e.alusrca = 1'b1; e.aluc = 3'b110; e.pcsrc = 2'b01;
         e.pcen = (o == 6'b000100) ? z : !z;
         push(1'($urandom_range(0, 1)), e);
      end else if (o == 6'b000010) begin
         e = blank(4'd11); e.pcsrc = 2'b10; e.pcen = 1'b1;
         push(1'($urandom_range(0, 1)), e);
      end else begin
         e = blank(4'd9); e.alusrca = 1'b1; e.alusrcb = 2'b10;
         e.aluc = (o == 6'b001100) ? 3'b000 : (o == 6'b001101) ? 3'b001 : 3'b010;
         e.ext_zero = (o != 6'b001000);
         push(1'($urandom_range(0, 1)), e);
         e = blank(4'd10); e.regwrite = 1'b1;
         push(1'($urandom_range(0, 1)), e);
      end
   endtask

   task automatic chk(input string tag, input exp_t obs, input exp_t ex);
      checks++;
      assert (obs === ex) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, ex);
      end
   endtask

   // Play n queued cycles (all if n<0) against the main DUT, then drop the rest.
   task automatic play_n(input string tag, input int n);
      int k;
      k = 0;
      while (eq.size() > 0 && (n < 0 || k < n)) begin
         mem_ready = rq.pop_front();
         #1;
         chk(tag, obs1, eq.pop_front());
         @(negedge clk);
         k++;
      end
      eq.delete();
      rq.delete();
   endtask

   // Hold reset two edges, check the forced strobes, release inside FETCH.
   task automatic do_reset();
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      mem_ready = 1'b1;
      #1;
      chk("reset_fetch", obs1, fetch_e(1'b0));
      reset = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [5:0] ops [10];
      logic [5:0] fns [7];
      exp_t e;
      reset = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b0;
      ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
              6'b001000, 6'b001100, 6'b001101, 6'b000010, 6'b111111};
      fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000, 6'b111111};

      do_reset();

      // R-type add, no waits
      op = 6'b000000; funct = 6'b100000;
      build(op, funct, 1'b0, 0, 0); play_n("rtype_add", -1);

      // LW with three wait cycles in MEMRD
      op = 6'b100011;
      build(op, funct, 1'b0, 0, 3); play_n("lw_wait3", -1);

      // BNE not taken / taken
      op = 6'b000101; zero = 1'b1;
      build(op, funct, zero, 0, 0); play_n("bne_z1", -1);
      zero = 1'b0;
      build(op, funct, zero, 0, 0); play_n("bne_z0", -1);

      // ORI on the full decoder
      op = 6'b001101;
      build(op, funct, zero, 1, 0); play_n("ori", -1);

      // ORI on the IMM_EN=0 instance: illegal in DECODE, back to FETCH
      do_reset();
      op = 6'b001101; mem_ready = 1'b1;
      #1; chk("noimm_fetch", obs2, fetch_e(1'b1));
      @(negedge clk); #1;
      e = blank(4'd1); e.alusrcb = 2'b11; e.aluc = 3'b010; e.ill = 1'b1;
      chk("noimm_decode", obs2, e);
      @(negedge clk); mem_ready = 1'b0; #1;
      chk("noimm_refetch", obs2, fetch_e(1'b0));
      @(negedge clk);

      // Reset during a MEMWR wait aborts the store
      do_reset();
      op = 6'b101011;
      build(op, funct, zero, 0, 5); play_n("sw_pre", 4);
      mem_ready = 1'b0; reset = 1'b1; #1;
      e = blank(4'd5); e.iord = 1'b1;
      chk("sw_reset_abort", obs1, e);
      @(negedge clk); mem_ready = 1'b1; #1;
      chk("sw_reset_fetch", obs1, fetch_e(1'b0));
      reset = 1'b0;

      // Unused state code recovers to FETCH
      @(negedge clk);
      mem_ready = 1'b0;
      force u_dut.state_r = state_t'(4'd13);
      #1; chk("state13", obs1, blank(4'd13));
      release u_dut.state_r;
      @(negedge clk); #1;
      chk("state13_recover", obs1, fetch_e(1'b0));

      // Randomized instruction stream
      for (int n = 0; n < 60; n++) begin
         op    = ops[$urandom_range(0, 9)];
         if (op == 6'b111111) op = 6'($urandom_range(0, 63));
         funct = fns[$urandom_range(0, 6)];
         if (funct == 6'b111111) funct = 6'($urandom_range(0, 63));
         zero  = 1'($urandom_range(0, 1));
         build(op, funct, zero, $urandom_range(0, 2), $urandom_range(0, 3));
         play_n("random", -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
